// File: rtl/seq_event_request.sv
// Event request generator: edge-detects det_in, spaces accepted events by a gap
// timer, counts them, and hands pending work to a controller over a 4-phase link.
module seq_event_request #(
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 16,
    parameter int GAP_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det_in,
    input  logic             req_ack,
    input  logic             clr_ovf,
    output logic             req_out,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic [15:0]      total_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] P_MAX      = '1;
    localparam logic [GAP_W-1:0] P_GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    logic             r_det_q;
    logic [GAP_W-1:0] r_gap;
    logic [CNT_W-1:0] r_pend;
    logic             r_ovf;
    logic [15:0]      r_total;
    state_t           r_state;
    logic             r_req;

    logic             w_raw;
    logic             w_accept;
    logic             w_done;
    logic             w_ovf_set;
    logic [CNT_W-1:0] w_pend_nxt;
    state_t           w_state_nxt;
    logic             w_req_nxt;

    assign w_raw    = det_in & ~r_det_q;
    assign w_accept = w_raw & (r_gap == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_det_q <= 1'b0;
            r_gap   <= '0;
        end else begin
            r_det_q <= det_in;
            if (w_accept)
                r_gap <= P_GAP_LOAD;
            else if (r_gap != '0)
                r_gap <= r_gap - GAP_W'(1);
        end
    end

    // An event and a completion on the same edge cancel out.
    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_set  = 1'b0;
        case ({w_accept, w_done})
            2'b10: begin
                if (r_pend == P_MAX)
                    w_ovf_set = 1'b1;
                else
                    w_pend_nxt = r_pend + CNT_W'(1);
            end
            2'b01: begin
                if (r_pend != '0)
                    w_pend_nxt = r_pend - CNT_W'(1);
            end
            default: w_pend_nxt = r_pend;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_total <= '0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_total <= r_total + 16'(w_accept);
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = (r_pend != '0) ? S_REQ : S_IDLE;
            S_REQ:   w_state_nxt = req_ack ? S_DROP : S_REQ;
            S_DROP:  w_state_nxt = req_ack ? S_DROP : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_done    = (r_state == S_REQ) & req_ack;
        w_req_nxt = (w_state_nxt == S_REQ);
    end

    assign req_out     = r_req;
    assign pending     = r_pend;
    assign overflow    = r_ovf;
    assign total_count = r_total;

endmodule

// File: tb/tb_seq_event_request.sv
// Scenario bench for seq_event_request: expected snapshots are queued as
// stimulus is driven and popped after the DUT edge that should produce them.
module tb_seq_event_request;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        det_in = 1'b0;
    logic        req_ack = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        req_out;
    logic [3:0]  pending;
    logic        overflow;
    logic [15:0] total_count;

    typedef struct {
        logic [3:0]  p;
        logic [15:0] t;
        logic        o;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_pass = 0;
    int          n_chk = 0;
    logic [15:0] exp_tot = 16'd0;

    seq_event_request #(
        .CNT_W(4),
        .GAP_CYCLES(16),
        .GAP_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .det_in(det_in),
        .req_ack(req_ack),
        .clr_ovf(clr_ovf),
        .req_out(req_out),
        .pending(pending),
        .overflow(overflow),
        .total_count(total_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (pending == 4'd0 && !req_out)
                break;
            if (req_out) begin
                req_ack = 1'b1;
                tick();
                req_ack = 1'b0;
            end
            tick();
        end
        idle(2);
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if ({req_out, pending, overflow, total_count} !== 22'd0)
            $display("FAIL reset_state: got r=%b p=%0d o=%b t=%0d, want all 0",
                     req_out, pending, overflow, total_count);
        else
            n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_tot = 16'd0;
        idle(2);
        n_chk++;
        if (req_out !== 1'b0)
            $display("FAIL reset_idle_req: got %b want 0", req_out);
        else
            n_pass++;
    endtask

    task automatic test_single();
        int w;
        int hi;
        det_in = 1'b1;
        exp_tot++;
        sb.push_back('{p: 4'd1, t: exp_tot, o: 1'b0});
        tick();
        det_in = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if ({pending, total_count, overflow} !== {e.p, e.t, e.o})
            $display("FAIL single_accept: got p=%0d t=%0d want p=%0d t=%0d",
                     pending, total_count, e.p, e.t);
        else
            n_pass++;
        n_chk++;
        if (req_out !== 1'b0)
            $display("FAIL single_req_early: got %b want 0", req_out);
        else
            n_pass++;
        w = 0;
        while (!req_out && w < 5) begin
            tick();
            w++;
        end
        n_chk++;
        if (w !== 1)
            $display("FAIL single_req_latency: got %0d want 1", w);
        else
            n_pass++;
        hi = 1;
        tick();
        hi += int'(req_out);
        tick();
        hi += int'(req_out);
        req_ack = 1'b1;
        sb.push_back('{p: 4'd0, t: exp_tot, o: 1'b0});
        tick();
        hi += int'(req_out);
        e = sb.pop_front();
        n_chk++;
        if ({pending, total_count, overflow} !== {e.p, e.t, e.o})
            $display("FAIL single_complete: got p=%0d t=%0d want p=%0d t=%0d",
                     pending, total_count, e.p, e.t);
        else
            n_pass++;
        req_ack = 1'b0;
        idle(3);
        hi += int'(req_out);
        n_chk++;
        if (hi !== 3)
            $display("FAIL single_req_width: got %0d want 3", hi);
        else
            n_pass++;
        idle(16);
    endtask

    task automatic test_gap();
        logic [3:0] ep;
        ep = 4'd0;
        for (int k = 0; k <= 16; k++) begin
            det_in = (k == 0 || k == 5 || k == 16);
            if (det_in) begin
                if (k != 5) begin
                    ep++;
                    exp_tot++;
                end
                sb.push_back('{p: ep, t: exp_tot, o: 1'b0});
            end
            tick();
            if (det_in) begin
                det_in = 1'b0;
                e = sb.pop_front();
                n_chk++;
                if ({pending, total_count, overflow} !== {e.p, e.t, e.o})
                    $display("FAIL gap_k%0d: got p=%0d t=%0d want p=%0d t=%0d",
                             k, pending, total_count, e.p, e.t);
                else
                    n_pass++;
            end
        end
        drain();
        n_chk++;
        if (pending !== 4'd0)
            $display("FAIL gap_drain: got %0d want 0", pending);
        else
            n_pass++;
        idle(16);
    endtask

    task automatic test_simul();
        int w;
        det_in = 1'b1;
        exp_tot++;
        sb.push_back('{p: 4'd1, t: exp_tot, o: 1'b0});
        tick();
        det_in = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if ({pending, total_count, overflow} !== {e.p, e.t, e.o})
            $display("FAIL simul_first: got p=%0d t=%0d want p=%0d t=%0d",
                     pending, total_count, e.p, e.t);
        else
            n_pass++;
        idle(15);
        n_chk++;
        if (req_out !== 1'b1)
            $display("FAIL simul_in_req: got %b want 1", req_out);
        else
            n_pass++;
        det_in = 1'b1;
        req_ack = 1'b1;
        exp_tot++;
        sb.push_back('{p: 4'd1, t: exp_tot, o: 1'b0});
        tick();
        det_in = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if ({pending, total_count, overflow, req_out} !== {e.p, e.t, e.o, 1'b0})
            $display("FAIL simul_both: got p=%0d t=%0d r=%b want p=%0d t=%0d r=0",
                     pending, total_count, req_out, e.p, e.t);
        else
            n_pass++;
        idle(2);
        n_chk++;
        if (req_out !== 1'b0)
            $display("FAIL simul_hold_drop: got %b want 0", req_out);
        else
            n_pass++;
        req_ack = 1'b0;
        w = 0;
        while (!req_out && w < 6) begin
            tick();
            w++;
        end
        n_chk++;
        if (w !== 2)
            $display("FAIL simul_reassert: got %0d cycles want 2", w);
        else
            n_pass++;
        drain();
        n_chk++;
        if (pending !== 4'd0)
            $display("FAIL simul_drain: got %0d want 0", pending);
        else
            n_pass++;
        idle(16);
    endtask

    task automatic test_saturation();
        logic [3:0] ep;
        for (int i = 0; i < 17; i++) begin
            det_in = 1'b1;
            clr_ovf = (i == 16);
            exp_tot++;
            ep = (i < 15) ? 4'(i + 1) : 4'd15;
            sb.push_back('{p: ep, t: exp_tot, o: (i >= 15)});
            tick();
            det_in = 1'b0;
            clr_ovf = 1'b0;
            e = sb.pop_front();
            n_chk++;
            if ({pending, total_count, overflow} !== {e.p, e.t, e.o})
                $display("FAIL sat_ev%0d: got p=%0d t=%0d o=%b want p=%0d t=%0d o=%b",
                         i, pending, total_count, overflow, e.p, e.t, e.o);
            else
                n_pass++;
            idle(15);
        end
        clr_ovf = 1'b1;
        sb.push_back('{p: 4'd15, t: exp_tot, o: 1'b0});
        tick();
        clr_ovf = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if ({pending, total_count, overflow} !== {e.p, e.t, e.o})
            $display("FAIL sat_clr: got p=%0d t=%0d o=%b want p=%0d t=%0d o=%b",
                     pending, total_count, overflow, e.p, e.t, e.o);
        else
            n_pass++;
        drain();
        n_chk++;
        if (pending !== 4'd0)
            $display("FAIL sat_drain: got %0d want 0", pending);
        else
            n_pass++;
        idle(16);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            det_in = 1'b1;
            tick();
            det_in = 1'b0;
            idle(15);
        end
        n_chk++;
        if ({pending, req_out} !== {4'd3, 1'b1})
            $display("FAIL rstmid_setup: got p=%0d r=%b want p=3 r=1", pending, req_out);
        else
            n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({req_out, pending, overflow, total_count} !== 22'd0)
            $display("FAIL rstmid_async: got r=%b p=%0d t=%0d want all 0",
                     req_out, pending, total_count);
        else
            n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_tot = 16'd0;
        idle(4);
        n_chk++;
        if ({req_out, pending} !== 5'd0)
            $display("FAIL rstmid_quiet: got r=%b p=%0d want 0", req_out, pending);
        else
            n_pass++;
        det_in = 1'b1;
        exp_tot++;
        sb.push_back('{p: 4'd1, t: exp_tot, o: 1'b0});
        tick();
        det_in = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if ({pending, total_count, overflow} !== {e.p, e.t, e.o})
            $display("FAIL rstmid_new: got p=%0d t=%0d want p=%0d t=%0d",
                     pending, total_count, e.p, e.t);
        else
            n_pass++;
        drain();
        idle(16);
    endtask

    task automatic test_held();
        det_in = 1'b1;
        exp_tot++;
        sb.push_back('{p: 4'd1, t: exp_tot, o: 1'b0});
        tick();
        e = sb.pop_front();
        n_chk++;
        if ({pending, total_count, overflow} !== {e.p, e.t, e.o})
            $display("FAIL held_first: got p=%0d t=%0d want p=%0d t=%0d",
                     pending, total_count, e.p, e.t);
        else
            n_pass++;
        idle(99);
        n_chk++;
        if ({pending, total_count} !== {4'd1, exp_tot})
            $display("FAIL held_once: got p=%0d t=%0d want p=1 t=%0d",
                     pending, total_count, exp_tot);
        else
            n_pass++;
        det_in = 1'b0;
        drain();
        idle(16);
    endtask

    task automatic test_reset_level();
        rst = 1'b1;
        det_in = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_tot = 16'd1;
        sb.push_back('{p: 4'd1, t: exp_tot, o: 1'b0});
        tick();
        det_in = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if ({pending, total_count, overflow} !== {e.p, e.t, e.o})
            $display("FAIL rstlvl_first: got p=%0d t=%0d want p=%0d t=%0d",
                     pending, total_count, e.p, e.t);
        else
            n_pass++;
        drain();
        idle(16);
    endtask

    task automatic test_wrap();
        force dut.r_total = 16'hFFFF;
        #1;
        release dut.r_total;
        n_chk++;
        if (total_count !== 16'hFFFF)
            $display("FAIL wrap_preload: got %h want ffff", total_count);
        else
            n_pass++;
        det_in = 1'b1;
        sb.push_back('{p: 4'd1, t: 16'h0000, o: 1'b0});
        tick();
        det_in = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if ({pending, total_count, overflow} !== {e.p, e.t, e.o})
            $display("FAIL wrap_event: got p=%0d t=%h want p=%0d t=%h",
                     pending, total_count, e.p, e.t);
        else
            n_pass++;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_simul();
        test_saturation();
        test_reset_mid();
        test_held();
        test_reset_level();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
